// File: rtl/arc4_ctrl_if.sv
// Bundle of ARC4 sequencer signals: start handshake, sub-block control, per-phase S memory requests and the S memory port.
interface arc4_ctrl_if #(
  parameter int KEY_W = 24
);
  logic             en;
  logic             rdy;
  logic [KEY_W-1:0] key;
  logic [1:0]       phase;
  logic             err;

  logic             init_en;
  logic             init_rdy;
  logic [7:0]       init_addr;
  logic [7:0]       init_wrdata;
  logic             init_wren;

  logic             ksa_en;
  logic             ksa_rdy;
  logic [KEY_W-1:0] ksa_key;
  logic [7:0]       ksa_addr;
  logic [7:0]       ksa_wrdata;
  logic             ksa_wren;
  logic [7:0]       ksa_rddata;

  logic             prga_en;
  logic             prga_rdy;
  logic [7:0]       prga_addr;
  logic [7:0]       prga_wrdata;
  logic             prga_wren;
  logic [7:0]       prga_rddata;

  logic [7:0]       s_addr;
  logic [7:0]       s_wrdata;
  logic             s_wren;
  logic [7:0]       s_rddata;

  modport master (
    input  en, key,
    input  init_rdy, init_addr, init_wrdata, init_wren,
    input  ksa_rdy, ksa_addr, ksa_wrdata, ksa_wren,
    input  prga_rdy, prga_addr, prga_wrdata, prga_wren,
    input  s_rddata,
    output rdy, phase, err,
    output init_en, ksa_en, ksa_key, ksa_rddata, prga_en, prga_rddata,
    output s_addr, s_wrdata, s_wren
  );

  modport slave (
    output en, key,
    output init_rdy, init_addr, init_wrdata, init_wren,
    output ksa_rdy, ksa_addr, ksa_wrdata, ksa_wren,
    output prga_rdy, prga_addr, prga_wrdata, prga_wren,
    output s_rddata,
    input  rdy, phase, err,
    input  init_en, ksa_en, ksa_key, ksa_rddata, prga_en, prga_rddata,
    input  s_addr, s_wrdata, s_wren
  );
endinterface

// File: rtl/arc4_ctrl.sv
// ARC4 top sequencer: runs init -> ksa -> prga and muxes the owning phase onto the single-port S memory.
// Define ARC4_CTRL_TIMEOUT_EN to add a per-RUN-state watchdog that aborts to IDLE with a one-cycle err pulse.
module arc4_ctrl #(
  parameter int KEY_W          = 24,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  arc4_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    INIT_START,
    INIT_RUN,
    KSA_START,
    KSA_RUN,
    PRGA_START,
    PRGA_RUN
  } state_t;

  state_t           state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic             timeout;

`ifdef ARC4_CTRL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_run;

  // Non-RUN states hold the counter at zero, so it starts fresh on every RUN entry.
  always_comb begin
    in_run  = (state_q == INIT_RUN) || (state_q == KSA_RUN) || (state_q == PRGA_RUN);
    cnt_d   = in_run ? cnt_q + 1'b1 : '0;
    timeout = in_run && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout            = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
    end
  end

  assign bus.ksa_key = key_q;

  always_comb begin
    state_d         = state_q;
    key_d           = key_q;
    bus.rdy         = 1'b0;
    bus.phase       = 2'd0;
    bus.err         = 1'b0;
    bus.init_en     = 1'b0;
    bus.ksa_en      = 1'b0;
    bus.prga_en     = 1'b0;
    bus.s_addr      = 8'd0;
    bus.s_wrdata    = 8'd0;
    bus.s_wren      = 1'b0;
    bus.ksa_rddata  = 8'd0;
    bus.prga_rddata = 8'd0;

    case (state_q)
      IDLE: begin
        bus.rdy = 1'b1;
        if (bus.en) begin
          key_d   = bus.key;
          state_d = INIT_START;
        end
      end
      INIT_START: begin
        bus.phase   = 2'd1;
        bus.init_en = bus.init_rdy;
        if (bus.init_rdy) state_d = INIT_RUN;
      end
      INIT_RUN: begin
        bus.phase    = 2'd1;
        bus.s_addr   = bus.init_addr;
        bus.s_wrdata = bus.init_wrdata;
        bus.s_wren   = bus.init_wren;
        if (bus.init_rdy) begin
          state_d = KSA_START;
        end else if (timeout) begin
          state_d    = IDLE;
          bus.err    = 1'b1;
          bus.s_wren = 1'b0;
        end
      end
      KSA_START: begin
        bus.phase  = 2'd2;
        bus.ksa_en = bus.ksa_rdy;
        if (bus.ksa_rdy) state_d = KSA_RUN;
      end
      KSA_RUN: begin
        bus.phase      = 2'd2;
        bus.s_addr     = bus.ksa_addr;
        bus.s_wrdata   = bus.ksa_wrdata;
        bus.s_wren     = bus.ksa_wren;
        bus.ksa_rddata = bus.s_rddata;
        if (bus.ksa_rdy) begin
          state_d = PRGA_START;
        end else if (timeout) begin
          state_d    = IDLE;
          bus.err    = 1'b1;
          bus.s_wren = 1'b0;
        end
      end
      PRGA_START: begin
        bus.phase   = 2'd3;
        bus.prga_en = bus.prga_rdy;
        if (bus.prga_rdy) state_d = PRGA_RUN;
      end
      PRGA_RUN: begin
        bus.phase       = 2'd3;
        bus.s_addr      = bus.prga_addr;
        bus.s_wrdata    = bus.prga_wrdata;
        bus.s_wren      = bus.prga_wren;
        bus.prga_rddata = bus.s_rddata;
        if (bus.prga_rdy) begin
          state_d = IDLE;
        end else if (timeout) begin
          state_d    = IDLE;
          bus.err    = 1'b1;
          bus.s_wren = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_arc4_ctrl.sv
// Scoreboard bench for arc4_ctrl: behavioural init/ksa/prga models and S memory push expected writes and start pulses.
module tb_arc4_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  arc4_ctrl_if #(.KEY_W(24)) bus ();

  arc4_ctrl #(.KEY_W(24), .TIMEOUT_CYCLES(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_wr_q[$];
  logic [1:0]  exp_en_q[$];
  logic [23:0] exp_key;
  bit          force_init_wr = 1'b0;
  bit          init_hang     = 1'b0;
  logic [7:0]  mem[256];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // S memory with registered read.
  initial for (int i = 0; i < 256; i++) mem[i] = 8'hEE;
  always @(posedge clk) begin
    if (bus.s_wren) mem[bus.s_addr] <= bus.s_wrdata;
    bus.s_rddata <= mem[bus.s_addr];
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.s_wren) begin
        if (exp_wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wr_unexpected: got addr %h data %h, none expected", bus.s_addr, bus.s_wrdata);
        end else begin
          check("s_write", {bus.s_addr, bus.s_wrdata}, exp_wr_q.pop_front());
        end
      end
      if (bus.init_en || bus.ksa_en || bus.prga_en) begin
        logic [1:0] id;
        id = bus.init_en ? 2'd1 : (bus.ksa_en ? 2'd2 : 2'd3);
        check("en_onehot", $countones({bus.init_en, bus.ksa_en, bus.prga_en}), 1);
        if (exp_en_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL en_unexpected: got pulse id %0d, none expected", id);
        end else begin
          check("en_pulse", id, exp_en_q.pop_front());
        end
        if (bus.ksa_en) check("ksa_key_at_en", bus.ksa_key, exp_key);
      end
    end
  end

  // Init model: writes S[i]=i for 256 cycles, or hangs busy forever when init_hang is set.
  initial begin : init_model
    int cnt;
    bit busy;
    bit en_s;
    busy = 0;
    cnt  = 0;
    bus.init_rdy = 1'b1;
    bus.init_addr = 8'h55;
    bus.init_wrdata = 8'h66;
    bus.init_wren = 1'b0;
    forever begin
      @(negedge clk);
      en_s = bus.init_en;
      @(posedge clk);
      #1;
      if (rst) begin
        busy = 0;
      end else if (!busy && en_s) begin
        busy = 1;
        cnt  = 0;
      end else if (busy && !init_hang) begin
        cnt++;
        if (cnt == 256) begin
          busy = 0;
          exp_en_q.push_back(2'd2);
        end
      end
      if (!busy) begin
        bus.init_rdy = 1'b1;
        bus.init_addr = 8'h55;
        bus.init_wrdata = 8'h66;
        bus.init_wren = force_init_wr;
      end else if (init_hang) begin
        bus.init_rdy = 1'b0;
        bus.init_wren = 1'b0;
      end else begin
        bus.init_rdy = 1'b0;
        bus.init_addr = 8'(cnt);
        bus.init_wrdata = 8'(cnt);
        bus.init_wren = 1'b1;
        exp_wr_q.push_back({8'(cnt), 8'(cnt)});
      end
    end
  end

  // KSA model: 8 cycles at addr k, writes A0+k for k>=4, checks read data of early reads.
  initial begin : ksa_model
    int cnt;
    bit busy;
    bit en_s;
    busy = 0;
    cnt  = 0;
    bus.ksa_rdy = 1'b1;
    bus.ksa_addr = 8'd0;
    bus.ksa_wrdata = 8'd0;
    bus.ksa_wren = 1'b0;
    forever begin
      @(negedge clk);
      en_s = bus.ksa_en;
      if (!rst && busy && cnt >= 1 && cnt <= 3) begin
        check("ksa_rddata", bus.ksa_rddata, cnt - 1);
        check("prga_rddata_gated", bus.prga_rddata, 0);
      end
      @(posedge clk);
      #1;
      if (rst) begin
        busy = 0;
      end else if (!busy && en_s) begin
        busy = 1;
        cnt  = 0;
      end else if (busy) begin
        cnt++;
        if (cnt == 8) begin
          busy = 0;
          exp_en_q.push_back(2'd3);
        end
      end
      if (!busy) begin
        bus.ksa_rdy = 1'b1;
        bus.ksa_addr = 8'd0;
        bus.ksa_wrdata = 8'd0;
        bus.ksa_wren = 1'b0;
      end else begin
        bus.ksa_rdy = 1'b0;
        bus.ksa_addr = 8'(cnt);
        bus.ksa_wrdata = 8'hA0 + 8'(cnt);
        bus.ksa_wren = (cnt >= 4);
        if (cnt >= 4) exp_wr_q.push_back({8'(cnt), 8'hA0 + 8'(cnt)});
      end
    end
  end

  // PRGA model: 4 cycles, writes on the first two; checks rdy returns exactly one cycle after prga_rdy.
  initial begin : prga_model
    int cnt;
    int chk;
    bit busy;
    bit en_s;
    busy = 0;
    cnt  = 0;
    chk  = 0;
    bus.prga_rdy = 1'b1;
    bus.prga_addr = 8'd0;
    bus.prga_wrdata = 8'd0;
    bus.prga_wren = 1'b0;
    forever begin
      @(negedge clk);
      en_s = bus.prga_en;
      if (chk == 1) begin
        check("rdy_while_prga_done", {bus.rdy, bus.phase}, {1'b0, 2'd3});
        chk = 2;
      end else if (chk == 2) begin
        check("rdy_after_prga_done", {bus.rdy, bus.phase}, {1'b1, 2'd0});
        chk = 0;
      end
      @(posedge clk);
      #1;
      if (rst) begin
        busy = 0;
        chk  = 0;
      end else if (!busy && en_s) begin
        busy = 1;
        cnt  = 0;
      end else if (busy) begin
        cnt++;
        if (cnt == 4) begin
          busy = 0;
          chk  = 1;
        end
      end
      if (!busy) begin
        bus.prga_rdy = 1'b1;
        bus.prga_addr = 8'd0;
        bus.prga_wrdata = 8'd0;
        bus.prga_wren = 1'b0;
      end else begin
        bus.prga_rdy = 1'b0;
        bus.prga_addr = 8'hF0 + 8'(cnt);
        bus.prga_wrdata = 8'h30 + 8'(cnt);
        bus.prga_wren = (cnt < 2);
        if (cnt < 2) exp_wr_q.push_back({8'hF0 + 8'(cnt), 8'h30 + 8'(cnt)});
      end
    end
  end

  task automatic start_run(input logic [23:0] k);
    tick;
    bus.key = k;
    exp_key = k;
    bus.en  = 1'b1;
    exp_en_q.push_back(2'd1);
    tick;
    bus.en  = 1'b0;
  endtask

  task automatic wait_phase(input logic [1:0] p, input int max);
    int n = 0;
    while (bus.phase != p && n < max) begin
      @(negedge clk);
      n++;
    end
    check("wait_phase", bus.phase, p);
  endtask

  task automatic wait_rdy(input int max);
    int n = 0;
    while (bus.rdy != 1'b1 && n < max) begin
      @(negedge clk);
      n++;
    end
    check("wait_rdy", bus.rdy, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdy_phase_err"}, {bus.rdy, bus.phase, bus.err}, {1'b1, 2'd0, 1'b0});
    check({tag, "_en_pulses"}, {bus.init_en, bus.ksa_en, bus.prga_en}, 0);
    check({tag, "_s_bus"}, {bus.s_wren, bus.s_addr, bus.s_wrdata}, 0);
    check({tag, "_ksa_key"}, bus.ksa_key, 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin : main
    rst = 1'b1;
    bus.en = 1'b0;
    bus.key = 24'h0;
    exp_key = 24'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    tick;
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", {bus.rdy, bus.phase}, {1'b1, 2'd0});

    // Run 1: full sequence, key change and ignored en during KSA, unowned init write during KSA.
    start_run(24'h00033C);
    @(negedge clk);
    check("init_en_first", {bus.init_en, bus.phase}, {1'b1, 2'd1});
    @(negedge clk);
    check("init_en_single", bus.init_en, 0);
    check("init_first_write", {bus.s_wren, bus.s_addr, bus.s_wrdata}, {1'b1, 8'd0, 8'd0});
    wait_phase(2'd2, 400);
    repeat (3) @(negedge clk);
    tick;
    force_init_wr = 1'b1;
    bus.key = 24'hFFFFFF;
    bus.en  = 1'b1;
    @(negedge clk);
    check("busy_rdy_low", bus.rdy, 0);
    tick;
    bus.en = 1'b0;
    wait_phase(2'd3, 50);
    check("ksa_key_held", bus.ksa_key, 24'h00033C);
    tick;
    force_init_wr = 1'b0;
    wait_rdy(50);
    check("phase_idle_after_run", bus.phase, 0);

    // Run 2: reset asserted asynchronously mid-KSA.
    start_run(24'h123456);
    wait_phase(2'd2, 400);
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    repeat (2) @(posedge clk);
    tick;
    rst = 1'b0;
    check("queues_after_rst", exp_wr_q.size() + exp_en_q.size(), 0);

    // Run 3: restart with a new key.
    start_run(24'h000018);
    wait_phase(2'd2, 400);
    @(negedge clk);
    check("ksa_key_restart", bus.ksa_key, 24'h000018);
    wait_rdy(600);

    // Init never completes.
    init_hang = 1'b1;
    start_run(24'h0000AA);
    @(negedge clk);
    check("hang_init_en", bus.init_en, 1);
`ifdef ARC4_CTRL_TIMEOUT_EN
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      if (j < 16) begin
        check("err_before_timeout", {bus.err, bus.phase}, {1'b0, 2'd1});
      end else begin
        check("err_pulse", {bus.err, bus.s_wren}, {1'b1, 1'b0});
      end
    end
    @(negedge clk);
    check("after_timeout", {bus.rdy, bus.phase, bus.err}, {1'b1, 2'd0, 1'b0});
`else
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      check("no_timeout", {bus.err, bus.phase, bus.rdy}, {1'b0, 2'd1, 1'b0});
    end
`endif
    tick;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    tick;
    rst = 1'b0;
    init_hang = 1'b0;
    repeat (3) @(negedge clk);
    check("final_idle", {bus.rdy, bus.phase}, {1'b1, 2'd0});
    check("final_queues_empty", exp_wr_q.size() + exp_en_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/arc4_ctrl.md
Name: arc4_ctrl

Overview:
Top-level sequencer for the ARC4 decryption core. Starts on an en/rdy request and runs the three S-memory phases in order: init, ksa, prga. Owns the single-port 256x8 S memory and muxes the address, write-data and write-enable of the active phase onto it. Latches the key for the ksa phase.

Parameters:
KEY_W, 24, width of the key latched on start and driven to ksa
TIMEOUT_CYCLES, 1024, watchdog limit per RUN state; used only with ARC4_CTRL_TIMEOUT_EN

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
en  in  1  start request, sampled only while rdy=1
rdy  out  1  1 = idle, can accept en
key  in  KEY_W  key, captured on accepted en
phase  out  2  0 idle, 1 init, 2 ksa, 3 prga
err  out  1  one-cycle watchdog abort pulse (optional feature)
init_en  out  1  start pulse to init
init_rdy  in  1  init idle
init_addr/init_wrdata  in  8/8  init memory request
init_wren  in  1  init write enable
ksa_en  out  1  start pulse to ksa
ksa_rdy  in  1  ksa idle
ksa_key  out  KEY_W  latched key
ksa_addr/ksa_wrdata  in  8/8  ksa memory request
ksa_wren  in  1  ksa write enable
ksa_rddata  out  8  S read data to ksa
prga_en  out  1  start pulse to prga
prga_rdy  in  1  prga idle
prga_addr/prga_wrdata  in  8/8  prga memory request
prga_wren  in  1  prga write enable
prga_rddata  out  8  S read data to prga
s_addr/s_wrdata  out  8/8  to S memory
s_wren  out  1  to S memory
s_rddata  in  8  from S memory (registered read, 1-cycle latency)

Behaviour:
- Reset (async, immediate): state IDLE. rdy=1. phase=0. err=0. All *_en=0. s_wren=0. s_addr=0. s_wrdata=0. Key register=0.
- States: IDLE, INIT_START, INIT_RUN, KSA_START, KSA_RUN, PRGA_START, PRGA_RUN.
- IDLE: rdy=1. When en=1 at a clock edge: latch key into ksa_key and go to INIT_START. en with rdy=0 is ignored and not queued.
- X_START: x_en = x_rdy (combinational). When x_rdy=1, go to X_RUN, so x_en is high for exactly one cycle. While x_rdy=0, wait with x_en=0.
- X_RUN: the sub-block drops rdy on the edge that samples its en, so the first RUN cycle sees x_rdy=0. The first cycle with x_rdy=1 moves INIT_RUN to KSA_START, KSA_RUN to PRGA_START, and PRGA_RUN to IDLE. rdy=1 in the cycle after prga_rdy is seen high.
- Memory mux is combinational from state:
  - INIT_RUN: s_* = init_*.
  - KSA_RUN: s_* = ksa_*.
  - PRGA_RUN: s_* = prga_*.
  - IDLE and all START states: s_wren=0, s_addr=0, s_wrdata=0.
- Read data: ksa_rddata = s_rddata only in KSA_RUN, else 0. prga_rddata = s_rddata only in PRGA_RUN, else 0.
- A request from a non-owning phase is never forwarded, even if its wren is asserted.
- phase: 1 for INIT_*, 2 for KSA_*, 3 for PRGA_*, 0 for IDLE.
- ksa_key holds from acceptance until the next accepted en. Changes on key mid-run have no effect.
- rst mid-operation: abort immediately to IDLE with reset outputs. Sub-blocks share rst and reset alongside.

Optional Feature:
ARC4_CTRL_TIMEOUT_EN:
- Defined: a counter clears on entry to each RUN state and increments every RUN cycle. If it reaches TIMEOUT_CYCLES before x_rdy=1:
  - go to IDLE;
  - pulse err=1 for one cycle;
  - s_wren=0 from that cycle on.
- Not defined: no counter; err tied 0; RUN states wait indefinitely.

Test Plan:
- Assert rst for 2 cycles -> rdy=1, phase=0, err=0, all *_en=0, s_wren=0, s_addr=0. Repeat with rst raised asynchronously between edges -> outputs reset without a clock.
- With a behavioural init model writing S[i]=i over 256 cycles: pulse en with key=24'h00033C -> init_en high exactly one cycle, one cycle after en. s_addr/s_wrdata track init_addr/init_wrdata for i=0..255 with s_wren=1. phase=1.
- After init_rdy returns 1 -> ksa_en single pulse, phase=2. ksa_key=24'h00033C even after key is changed to 24'hFFFFFF mid-KSA. init_wren forced 1 during KSA -> s_wren follows ksa_wren only.
- Complete prga -> rdy=1 exactly one cycle after prga_rdy seen high, phase=0. en pulsed during KSA -> ignored: no extra init_en, no restart.
- rst asserted mid-KSA, then new en with key=24'h000018 -> sequence restarts at init, ksa_key=24'h000018.
- ARC4_CTRL_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, init model never returns rdy -> err=1 for one cycle 16 cycles into INIT_RUN, then rdy=1, phase=0. Without the macro, err stays 0 and phase stays 1.
